smaesh_op_scheduler: RTL and testbench
======================================

# smaesh_op_scheduler

Sequential scheduler that shares the masked AES core, key holder and PRNG among three request classes: data runs, re-keying and re-seeding. It sits between the external valid/ready streams and the top-level core instance. It replaces the free-running combinational start conditions with an explicit arbitration FSM. Each grant is held until the served resource signals completion, so one operation never starves or corrupts another.

## Interface
Parameters:
- RESEED_LIMIT, 1024: number of data runs allowed between two reseeds (≥1); used only when auto-reseed is compiled in.
- CNT_W, 11: width of run counter; must satisfy 2^CNT_W > RESEED_LIMIT.
- BUSY_TMO, 4: cycles allowed after a start pulse for the served busy to assert.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data_valid  in  1  data run requested.
- in_key_valid  in  1  re-key requested.
- in_seed_valid  in  1  reseed requested.
- aes_ready_in  in  1  core can accept a run.
- prng_out_valid  in  1  PRNG randomness available.
- aes_busy  in  1  core active.
- ksu_busy  in  1  key holder fetching.
- prng_busy  in  1  PRNG reseeding.
- data_start  out  1  1-cycle pulse: core accepts data (drives core valid_in and in_data_ready).
- key_start  out  1  1-cycle pulse: start key fetch procedure.
- seed_start  out  1  1-cycle pulse: start PRNG reseed (doubles as in_seed_ready).
- sched_state  out  2  FSM state: 0 IDLE, 1 RUN_DATA, 2 RUN_KEY, 3 RUN_SEED.
- reseed_required  out  1  data grants blocked pending reseed.
- run_count  out  CNT_W  data runs since last reseed.
- err_tmo  out  1  sticky: served busy never asserted within BUSY_TMO.

## Operation
- The resource is free when aes_busy, ksu_busy and prng_busy are all 0.
- IDLE: grant is evaluated every cycle when the resource is free. Eligibility:
  - Seed: in_seed_valid.
  - Key: in_key_valid.
  - Data: in_data_valid & aes_ready_in & prng_out_valid & ~reseed_required.
- Priority: seed > key > data.
- Anti-starvation: flag data_turn is set when a RUN_KEY or RUN_SEED returns to IDLE while in_data_valid=1. When data_turn=1 and data is eligible, data wins. data_turn clears on data_start or when in_data_valid=0.
- A grant pulses the matching *_start for exactly one cycle and moves the FSM to RUN_DATA, RUN_KEY or RUN_SEED.
- RUN_x:
  - Track the served busy (RUN_DATA: aes_busy; RUN_KEY: ksu_busy; RUN_SEED: prng_busy).
  - Set busy_seen when that busy is 1.
  - Return to IDLE on the first cycle with busy_seen=1 and busy=0.
  - If busy is not seen within BUSY_TMO cycles of the start pulse, return to IDLE and set err_tmo.
- No start pulse is issued outside IDLE.
- Simultaneous requests in the same cycle are resolved only by the priority and data_turn rules. A request that drops its valid before being granted is simply forgotten.

## Timing
- Reset (rst_n=0, asynchronous) values:
  - sched_state=IDLE; all *_start=0; run_count=0; reset value of reseed_required given under Configuration; err_tmo=0; data_turn=0; busy_seen=0.
- Reset mid-operation aborts the RUN state immediately; the scheduler does not wait for busy.
- Grant latency: the *_start pulse is combinational in the same cycle the eligibility is met in IDLE. sched_state changes on the next edge.
- Minimum occupancy per operation: start cycle + 1 busy cycle + 1 cycle to return. Back-to-back operations are therefore ≥3 cycles apart.
- run_count increments on the edge after data_start and saturates at RESEED_LIMIT. It clears to 0 on the RUN_SEED→IDLE transition, including a timeout exit. If data_start and that clear occur in the same cycle, the clear wins.

## Configuration
- SCHED_AUTO_RESEED_EN defined:
  - reseed_required = (run_count == RESEED_LIMIT), registered.
  - When reseed_required=1, data is ineligible; key and seed requests are still served.
  - reseed_required clears together with run_count.
- SCHED_AUTO_RESEED_EN undefined:
  - The comparison logic is removed and reseed_required is tied 0.
  - run_count still counts, saturating at 2^CNT_W−1, and is still cleared by reseeds.

## Test plan
- Reset, then in_data_valid=1, aes_ready_in=1, prng_out_valid=1, resource free → data_start high for 1 cycle. With aes_busy high for 20 cycles, sched_state goes 1 then back to 0 one cycle after aes_busy falls; run_count=1.
- in_seed_valid, in_key_valid and in_data_valid all asserted in the same cycle → seed_start first. After prng_busy completes, data_start, because data_turn beats the pending key. key_start follows the data run.
- key_start issued but ksu_busy is never asserted (BUSY_TMO=4) → FSM returns to IDLE after 4 cycles and err_tmo=1 sticky until reset.
- SCHED_AUTO_RESEED_EN, RESEED_LIMIT=3, three data runs → reseed_required=1 and further in_data_valid gets no data_start. After in_seed_valid and a completed reseed: run_count=0, reseed_required=0, and data is granted again.
- rst_n pulsed low during RUN_DATA while aes_busy=1 → outputs return to reset values asynchronously. After rst_n rises, the FSM is in IDLE and waits for aes_busy=0 before any new grant.

Source files
------------

// File: rtl/smaesh_op_scheduler_if.sv
// smaesh_op_scheduler_if
// Request/handshake bundle between the external valid/ready streams, the
// shared resources (AES core, key holder, PRNG) and the operation scheduler.
// master: the environment side (requests, readiness, busy flags).
// slave : the scheduler side (one-cycle start pulses).
interface smaesh_op_scheduler_if;
   logic in_data_valid;
   logic in_key_valid;
   logic in_seed_valid;
   logic aes_ready_in;
   logic prng_out_valid;
   logic aes_busy;
   logic ksu_busy;
   logic prng_busy;
   logic data_start;
   logic key_start;
   logic seed_start;

   modport master (
      output in_data_valid, in_key_valid, in_seed_valid,
      output aes_ready_in, prng_out_valid,
      output aes_busy, ksu_busy, prng_busy,
      input  data_start, key_start, seed_start
   );

   modport slave (
      input  in_data_valid, in_key_valid, in_seed_valid,
      input  aes_ready_in, prng_out_valid,
      input  aes_busy, ksu_busy, prng_busy,
      output data_start, key_start, seed_start
   );
endinterface

// File: rtl/smaesh_op_scheduler.sv
// smaesh_op_scheduler
// Arbitrates the shared masked AES core / key holder / PRNG between data runs,
// re-keying and re-seeding. A grant is a one-cycle start pulse issued from IDLE;
// the FSM then holds the resource until the served busy has been seen and has
// dropped again, or until the busy fails to appear within BUSY_TMO cycles.
// Optional feature: define SCHED_AUTO_RESEED_EN to block data grants once
// RESEED_LIMIT data runs have happened since the last reseed.
module smaesh_op_scheduler #(
   parameter int RESEED_LIMIT = 1024,
   parameter int CNT_W        = 11,
   parameter int BUSY_TMO     = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   smaesh_op_scheduler_if.slave bus,
   output logic [1:0]           sched_state,
   output logic                 reseed_required,
   output logic [CNT_W-1:0]     run_count,
   output logic                 err_tmo
);

   localparam int TMO_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

   // Reject parameter sets the counter cannot represent.
   if (RESEED_LIMIT < 1 || BUSY_TMO < 1 || CNT_W < 1 || CNT_W > 31 ||
       (32'd1 << CNT_W) <= RESEED_LIMIT) begin : g_cfg_err
      $error("smaesh_op_scheduler: invalid RESEED_LIMIT/CNT_W/BUSY_TMO");
   end

`ifdef SCHED_AUTO_RESEED_EN
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(RESEED_LIMIT);
`else
   localparam logic [CNT_W-1:0] CNT_SAT = '1;
`endif

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN_DATA = 2'd1,
      S_RUN_KEY  = 2'd2,
      S_RUN_SEED = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic             busy_seen_q, busy_seen_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             data_turn_q, data_turn_d;
   logic [CNT_W-1:0] run_count_q, run_count_d;
   logic             err_tmo_q, err_tmo_d;
   logic             reseed_req;

   logic             free;
   logic             data_elig;
   logic             data_go, key_go, seed_go;
   logic             served_busy;
   logic             run_exit;

   assign free      = ~(bus.aes_busy | bus.ksu_busy | bus.prng_busy);
   assign data_elig = bus.in_data_valid & bus.aes_ready_in & bus.prng_out_valid & ~reseed_req;

   // Grant arbitration, busy tracking and timeout for the current operation.
   always_comb begin
      state_d     = state_q;
      busy_seen_d = busy_seen_q;
      tmo_cnt_d   = tmo_cnt_q;
      err_tmo_d   = err_tmo_q;
      data_go     = 1'b0;
      key_go      = 1'b0;
      seed_go     = 1'b0;
      served_busy = 1'b0;
      run_exit    = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy_seen_d = 1'b0;
            tmo_cnt_d   = '0;
            if (free) begin
               // data_turn lets a waiting data run jump ahead once after a key/seed op
               if (data_turn_q && data_elig)  data_go = 1'b1;
               else if (bus.in_seed_valid)    seed_go = 1'b1;
               else if (bus.in_key_valid)     key_go  = 1'b1;
               else if (data_elig)            data_go = 1'b1;
            end
            if (data_go)      state_d = S_RUN_DATA;
            else if (seed_go) state_d = S_RUN_SEED;
            else if (key_go)  state_d = S_RUN_KEY;
         end
         default: begin
            case (state_q)
               S_RUN_DATA: served_busy = bus.aes_busy;
               S_RUN_KEY:  served_busy = bus.ksu_busy;
               default:    served_busy = bus.prng_busy;
            endcase
            if (served_busy) begin
               busy_seen_d = 1'b1;
            end else if (busy_seen_q) begin
               state_d  = S_IDLE;
               run_exit = 1'b1;
            end else if (tmo_cnt_q == TMO_LAST) begin
               state_d   = S_IDLE;
               run_exit  = 1'b1;
               err_tmo_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
      endcase
   end

   // Anti-starvation flag and run counter; a reseed exit clears the counter
   // even if it coincides with a data grant.
   always_comb begin
      data_turn_d = data_turn_q;
      if (data_go || !bus.in_data_valid) data_turn_d = 1'b0;
      if (run_exit && state_q != S_RUN_DATA && bus.in_data_valid) data_turn_d = 1'b1;

      run_count_d = run_count_q;
      if (run_exit && state_q == S_RUN_SEED)        run_count_d = '0;
      else if (data_go && run_count_q != CNT_SAT)   run_count_d = run_count_q + 1'b1;
   end

   // Control state registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         busy_seen_q <= 1'b0;
         tmo_cnt_q   <= '0;
         data_turn_q <= 1'b0;
         run_count_q <= '0;
         err_tmo_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         busy_seen_q <= busy_seen_d;
         tmo_cnt_q   <= tmo_cnt_d;
         data_turn_q <= data_turn_d;
         run_count_q <= run_count_d;
         err_tmo_q   <= err_tmo_d;
      end
   end

`ifdef SCHED_AUTO_RESEED_EN
   logic reseed_req_q, reseed_req_d;

   assign reseed_req_d = (run_count_d == CNT_SAT);

   // Reseed-required flag tracks the counter value it is registered with.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) reseed_req_q <= 1'b0;
      else        reseed_req_q <= reseed_req_d;
   end

   assign reseed_req = reseed_req_q;
`else
   assign reseed_req = 1'b0;
`endif

   assign bus.data_start  = data_go;
   assign bus.key_start   = key_go;
   assign bus.seed_start  = seed_go;
   assign sched_state     = state_q;
   assign reseed_required = reseed_req;
   assign run_count       = run_count_q;
   assign err_tmo         = err_tmo_q;

endmodule

// File: tb/tb_smaesh_op_scheduler.sv
// tb_smaesh_op_scheduler
// Directed bench for smaesh_op_scheduler (RESEED_LIMIT=3, CNT_W=3, BUSY_TMO=4).
// Honours SCHED_AUTO_RESEED_EN when the design is built with it.
module tb_smaesh_op_scheduler;
   localparam int RESEED_LIMIT = 3;
   localparam int CNT_W        = 3;
   localparam int BUSY_TMO     = 4;

   logic             clk;
   logic             rst_n;
   logic [1:0]       sched_state;
   logic             reseed_required;
   logic [CNT_W-1:0] run_count;
   logic             err_tmo;

   int n_chk;
   int n_fail;

   smaesh_op_scheduler_if bus ();

   smaesh_op_scheduler #(
      .RESEED_LIMIT (RESEED_LIMIT),
      .CNT_W        (CNT_W),
      .BUSY_TMO     (BUSY_TMO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (bus.slave),
      .sched_state     (sched_state),
      .reseed_required (reseed_required),
      .run_count       (run_count),
      .err_tmo         (err_tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // One complete data run with a single busy cycle; exp_cnt is the count after it.
   task automatic do_data_run(input string tag, input int exp_cnt);
      tick();
      bus.in_data_valid = 1'b1;
      #1;
      check({tag, "_start"}, 32'(bus.data_start), 32'd1);
      tick();
      bus.in_data_valid = 1'b0;
      bus.aes_busy      = 1'b1;
      check({tag, "_state"}, 32'(sched_state), 32'd1);
      check({tag, "_cnt"}, 32'(run_count), 32'(exp_cnt));
      tick();
      bus.aes_busy = 1'b0;
      tick();
      check({tag, "_idle"}, 32'(sched_state), 32'd0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      bus.in_data_valid  = 1'b0;
      bus.in_key_valid   = 1'b0;
      bus.in_seed_valid  = 1'b0;
      bus.aes_ready_in   = 1'b0;
      bus.prng_out_valid = 1'b0;
      bus.aes_busy       = 1'b0;
      bus.ksu_busy       = 1'b0;
      bus.prng_busy      = 1'b0;
      rst_n = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_state", 32'(sched_state), 32'd0);
      check("rst_starts", 32'({bus.data_start, bus.key_start, bus.seed_start}), 32'd0);
      check("rst_cnt", 32'(run_count), 32'd0);
      check("rst_reseed", 32'(reseed_required), 32'd0);
      check("rst_err", 32'(err_tmo), 32'd0);
      rst_n = 1'b1;

      // Single data run, 20 busy cycles
      tick();
      bus.in_data_valid  = 1'b1;
      bus.aes_ready_in   = 1'b1;
      bus.prng_out_valid = 1'b1;
      #1;
      check("d1_start", 32'({bus.data_start, bus.key_start, bus.seed_start}), 32'b100);
      tick();
      bus.in_data_valid = 1'b0;
      bus.aes_busy      = 1'b1;
      check("d1_state", 32'(sched_state), 32'd1);
      check("d1_cnt", 32'(run_count), 32'd1);
      check("d1_nostart", 32'(bus.data_start), 32'd0);
      repeat (19) tick();
      check("d1_hold", 32'(sched_state), 32'd1);
      tick();
      bus.aes_busy = 1'b0;
      check("d1_lastbusy", 32'(sched_state), 32'd1);
      tick();
      check("d1_ret", 32'(sched_state), 32'd0);
      check("d1_cnt2", 32'(run_count), 32'd1);

      // Seed, key and data together: seed, then data (data_turn), then key
      bus.in_seed_valid = 1'b1;
      bus.in_key_valid  = 1'b1;
      bus.in_data_valid = 1'b1;
      #1;
      check("p_seed", 32'({bus.data_start, bus.key_start, bus.seed_start}), 32'b001);
      tick();
      bus.in_seed_valid = 1'b0;
      bus.prng_busy     = 1'b1;
      check("p_seedst", 32'(sched_state), 32'd3);
      tick();
      bus.prng_busy = 1'b0;
      #1;
      check("p_seedhold", 32'({bus.data_start, bus.key_start, bus.seed_start}), 32'b000);
      tick();
      #1;
      check("p_data", 32'({bus.data_start, bus.key_start, bus.seed_start}), 32'b100);
      check("p_cntclr", 32'(run_count), 32'd0);
      tick();
      bus.in_data_valid = 1'b0;
      bus.aes_busy      = 1'b1;
      check("p_datast", 32'(sched_state), 32'd1);
      tick();
      bus.aes_busy = 1'b0;
      tick();
      #1;
      check("p_key", 32'({bus.data_start, bus.key_start, bus.seed_start}), 32'b010);
      tick();
      bus.in_key_valid = 1'b0;
      bus.ksu_busy     = 1'b1;
      check("p_keyst", 32'(sched_state), 32'd2);
      tick();
      bus.ksu_busy = 1'b0;
      tick();
      check("p_keyret", 32'(sched_state), 32'd0);
      check("p_noerr", 32'(err_tmo), 32'd0);

      // Key fetch whose busy never shows up
      bus.in_key_valid = 1'b1;
      #1;
      check("t_start", 32'(bus.key_start), 32'd1);
      tick();
      bus.in_key_valid = 1'b0;
      check("t_run1", 32'(sched_state), 32'd2);
      repeat (3) tick();
      check("t_run4", 32'(sched_state), 32'd2);
      check("t_noerr", 32'(err_tmo), 32'd0);
      tick();
      check("t_ret", 32'(sched_state), 32'd0);
      check("t_err", 32'(err_tmo), 32'd1);

      // Reseed to zero the count, then the reseed-limit behaviour
      bus.in_seed_valid = 1'b1;
      #1;
      check("r_seed", 32'(bus.seed_start), 32'd1);
      tick();
      bus.in_seed_valid = 1'b0;
      bus.prng_busy     = 1'b1;
      tick();
      bus.prng_busy = 1'b0;
      tick();
      check("r_cnt0", 32'(run_count), 32'd0);
      check("r_errsticky", 32'(err_tmo), 32'd1);
      do_data_run("r1", 1);
      do_data_run("r2", 2);
      do_data_run("r3", 3);
`ifdef SCHED_AUTO_RESEED_EN
      check("r_req", 32'(reseed_required), 32'd1);
      tick();
      bus.in_data_valid = 1'b1;
      #1;
      check("r_blocked", 32'(bus.data_start), 32'd0);
      tick();
      check("r_blocked2", 32'(bus.data_start), 32'd0);
      check("r_cntsat", 32'(run_count), 32'd3);
`else
      check("r_req", 32'(reseed_required), 32'd0);
      do_data_run("r4", 4);
`endif
      tick();
      bus.in_data_valid = 1'b1;
      bus.in_seed_valid = 1'b1;
      #1;
      check("r_seedwin", 32'({bus.data_start, bus.key_start, bus.seed_start}), 32'b001);
      tick();
      bus.in_seed_valid = 1'b0;
      bus.prng_busy     = 1'b1;
      check("r_seedst", 32'(sched_state), 32'd3);
      tick();
      bus.prng_busy = 1'b0;
      tick();
      #1;
      check("r_cntclr", 32'(run_count), 32'd0);
      check("r_reqclr", 32'(reseed_required), 32'd0);
      check("r_regrant", 32'(bus.data_start), 32'd1);
      tick();
      bus.in_data_valid = 1'b0;
      bus.aes_busy      = 1'b1;
      check("r_run", 32'(sched_state), 32'd1);
      check("r_cnt1", 32'(run_count), 32'd1);

      // Asynchronous reset in the middle of a data run
      #2;
      rst_n = 1'b0;
      #1;
      check("a_state", 32'(sched_state), 32'd0);
      check("a_cnt", 32'(run_count), 32'd0);
      check("a_err", 32'(err_tmo), 32'd0);
      check("a_reseed", 32'(reseed_required), 32'd0);
      tick();
      rst_n = 1'b1;
      bus.in_data_valid = 1'b1;
      #1;
      check("a_wait1", 32'(bus.data_start), 32'd0);
      tick();
      check("a_wait2", 32'(bus.data_start), 32'd0);
      check("a_idle", 32'(sched_state), 32'd0);
      bus.aes_busy = 1'b0;
      #1;
      check("a_grant", 32'(bus.data_start), 32'd1);
      tick();
      bus.in_data_valid = 1'b0;
      bus.aes_busy      = 1'b1;
      check("a_run", 32'(sched_state), 32'd1);
      check("a_cnt1", 32'(run_count), 32'd1);
      tick();
      bus.aes_busy = 1'b0;
      tick();
      check("a_ret", 32'(sched_state), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
